// File: rtl/sync_filter_bank_pkg.sv
// Shared constants and helpers for the synchronizer / glitch-filter bank.
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 3;
  localparam int SYNC_FILT_DEF   = 4;
  localparam int EVT_CNT_W       = 8;

  // Ceiling log2; callers pass FILT_CNT+1 so a count of FILT_CNT-1 always fits.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flop-chain synchronizer, stability filter, edge pulses.
// Optional rise-event counter when SYNC_FILTER_EVENT_CNT_EN is defined.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int STAGES    = SYNC_STAGES_DEF,
  parameter int FILT_CNT  = SYNC_FILT_DEF,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SYNC_FILTER_EVENT_CNT_EN
  input  logic                 evt_clr_i,
  output logic [EVT_CNT_W-1:0] evt_cnt_o,
`endif
  input  logic                 async_i,
  output logic                 sync_o,
  output logic                 filt_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  localparam int CNT_W = clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [STAGES-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              filt_q, filt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              sync;

  assign chain_d = {chain_q[STAGES-2:0], async_i};
  assign sync    = chain_q[STAGES-1];

  // The pulse is registered on the same edge the new level is accepted,
  // so it lines up with the first cycle filt_o shows that level.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      cnt_q   <= '0;
      filt_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_o = sync;
  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef SYNC_FILTER_EVENT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_q, evt_d;

  // Counts rise pulses as they are presented; a clear in the same cycle wins.
  always_comb begin
    evt_d = evt_q;
    if (evt_clr_i) begin
      evt_d = '0;
    end else if (rise_q && (evt_q != {EVT_CNT_W{1'b1}})) begin
      evt_d = evt_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_cnt_o = evt_q;
`endif

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer + glitch filter + edge detector bank.
// Define SYNC_FILTER_EVENT_CNT_EN to add per-channel rise-event counters.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int STAGES    = SYNC_STAGES_DEF,
  parameter int FILT_CNT  = SYNC_FILT_DEF,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef SYNC_FILTER_EVENT_CNT_EN
  input  logic                          evt_clr,
  output logic [CHANNELS*EVT_CNT_W-1:0] evt_cnt,
`endif
  input  logic [CHANNELS-1:0]           async_in,
  output logic [CHANNELS-1:0]           sync_out,
  output logic [CHANNELS-1:0]           filt_out,
  output logic [CHANNELS-1:0]           rise_pulse,
  output logic [CHANNELS-1:0]           fall_pulse,
  output logic                          any_change
);

  if (STAGES < 2 || FILT_CNT < 1 || CHANNELS < 1) begin : g_param_err
    $error("sync_filter_bank: need STAGES >= 2, FILT_CNT >= 1, CHANNELS >= 1");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    sync_filter_ch #(
      .STAGES    (STAGES),
      .FILT_CNT  (FILT_CNT),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SYNC_FILTER_EVENT_CNT_EN
      .evt_clr_i (evt_clr),
      .evt_cnt_o (evt_cnt[ch*EVT_CNT_W +: EVT_CNT_W]),
`endif
      .async_i   (async_in[ch]),
      .sync_o    (sync_out[ch]),
      .filt_o    (filt_out[ch]),
      .rise_o    (rise_pulse[ch]),
      .fall_o    (fall_pulse[ch])
    );
  end

  assign any_change = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench: three parameterisations of sync_filter_bank checked
// against a history-based model plus directed literal checks.
module tb_sync_filter_bank;

  localparam int CH = 4;
  localparam int NI = 3;
  localparam int S_P [NI] = '{3, 2, 5};
  localparam int F_P [NI] = '{4, 1, 6};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] async_in = '0;
  logic [CH-1:0] sync_o [NI];
  logic [CH-1:0] filt_o [NI];
  logic [CH-1:0] rise_o [NI];
  logic [CH-1:0] fall_o [NI];
  logic          any_o  [NI];
`ifdef SYNC_FILTER_EVENT_CNT_EN
  logic          evt_clr = 1'b0;
  logic [31:0]   evt_o  [NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_filter_bank u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef SYNC_FILTER_EVENT_CNT_EN
    .evt_clr(evt_clr), .evt_cnt(evt_o[0]),
`endif
    .async_in(async_in), .sync_out(sync_o[0]), .filt_out(filt_o[0]),
    .rise_pulse(rise_o[0]), .fall_pulse(fall_o[0]), .any_change(any_o[0])
  );

  sync_filter_bank #(.STAGES(2), .FILT_CNT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SYNC_FILTER_EVENT_CNT_EN
    .evt_clr(evt_clr), .evt_cnt(evt_o[1]),
`endif
    .async_in(async_in), .sync_out(sync_o[1]), .filt_out(filt_o[1]),
    .rise_pulse(rise_o[1]), .fall_pulse(fall_o[1]), .any_change(any_o[1])
  );

  sync_filter_bank #(.STAGES(5), .FILT_CNT(6)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef SYNC_FILTER_EVENT_CNT_EN
    .evt_clr(evt_clr), .evt_cnt(evt_o[2]),
`endif
    .async_in(async_in), .sync_out(sync_o[2]), .filt_out(filt_o[2]),
    .rise_pulse(rise_o[2]), .fall_pulse(fall_o[2]), .any_change(any_o[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: hist[t] is async_in as sampled at edge t after reset release.
  // Before edge t the chain output equals async from edge t-STAGES, and the
  // filtered level flips at edge t iff that pre-edge value has been the
  // opposite level on each of the last FILT_CNT edges.
  logic [CH-1:0] hist [$];
  logic [CH-1:0] m_sync [NI];
  logic [CH-1:0] m_filt [NI];
  logic [CH-1:0] m_rise [NI];
  logic [CH-1:0] m_fall [NI];
  int            m_evt  [CH];

  function automatic logic [CH-1:0] hist_at(input int idx);
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        for (int i = 0; i < NI; i++) begin
          m_sync[i] = '0; m_filt[i] = '0; m_rise[i] = '0; m_fall[i] = '0;
        end
        for (int c = 0; c < CH; c++) m_evt[c] = 0;
      end else begin
        int t;
        t = hist.size();
`ifdef SYNC_FILTER_EVENT_CNT_EN
        for (int c = 0; c < CH; c++) begin
          if (evt_clr) m_evt[c] = 0;
          else if (m_rise[0][c] && m_evt[c] < 255) m_evt[c] = m_evt[c] + 1;
        end
`endif
        hist.push_back(async_in);
        for (int i = 0; i < NI; i++) begin
          logic [CH-1:0] r, f;
          r = '0;
          f = '0;
          for (int c = 0; c < CH; c++) begin
            logic tgt, flip;
            logic [CH-1:0] v;
            tgt  = ~m_filt[i][c];
            flip = 1'b1;
            for (int j = 0; j < F_P[i]; j++) begin
              v = hist_at(t - j - S_P[i]);
              if (v[c] !== tgt) flip = 1'b0;
            end
            if (flip) begin
              m_filt[i][c] = tgt;
              r[c] = tgt;
              f[c] = ~tgt;
            end
          end
          m_rise[i] = r;
          m_fall[i] = f;
          m_sync[i] = hist_at(t - S_P[i] + 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d.sync_out", i), 32'(sync_o[i]), 32'(m_sync[i]));
        check($sformatf("u%0d.filt_out", i), 32'(filt_o[i]), 32'(m_filt[i]));
        check($sformatf("u%0d.rise_pulse", i), 32'(rise_o[i]), 32'(m_rise[i]));
        check($sformatf("u%0d.fall_pulse", i), 32'(fall_o[i]), 32'(m_fall[i]));
        check($sformatf("u%0d.any_change", i), 32'(any_o[i]), 32'(|{m_rise[i], m_fall[i]}));
      end
`ifdef SYNC_FILTER_EVENT_CNT_EN
      check("u0.evt_cnt", evt_o[0],
            {8'(m_evt[3]), 8'(m_evt[2]), 8'(m_evt[1]), 8'(m_evt[0])});
`endif
    end
  end

  // Waits up to budget edges for any_change on u0; reports edges taken.
  task automatic wait_any0(input int budget, output int edges, output bit found);
    found = 1'b0;
    edges = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (any_o[0]) begin
        found = 1'b1;
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int  edges, hi_cnt, pulse_cnt;
    bit  found, moved;
    int  hold [CH];

    // Reset state and start-up acceptance of a non-reset level
    rst_n = 1'b0;
    async_in = 4'hF;
    repeat (3) @(negedge clk);
    check("rst.filt", 32'(filt_o[0]), 32'h0);
    check("rst.sync", 32'(sync_o[0]), 32'h0);
    check("rst.any", 32'(any_o[0]), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("start.rise_first", 32'(rise_o[0]), 32'h0);
      if (k == 6) check("start.filt_e6", 32'(filt_o[0]), 32'h0);
      if (k == 7) begin
        check("start.filt_e7", 32'(filt_o[0]), 32'hF);
        check("start.rise_e7", 32'(rise_o[0]), 32'hF);
        check("start.any_e7", 32'(any_o[0]), 32'h1);
      end
      if (k == 8) begin
        check("start.rise_e8", 32'(rise_o[0]), 32'h0);
        check("start.any_e8", 32'(any_o[0]), 32'h0);
      end
      if (k == 2) check("lat.s2f1_e2", 32'(rise_o[1]), 32'h0);
      if (k == 3) check("lat.s2f1_e3", 32'(rise_o[1]), 32'hF);
      if (k == 10) check("lat.s5f6_e10", 32'(rise_o[2]), 32'h0);
      if (k == 11) check("lat.s5f6_e11", 32'(rise_o[2]), 32'hF);
    end

    // Glitch rejection: 3-cycle high on bit0
    @(negedge clk);
    async_in = 4'h0;
    repeat (15) @(negedge clk);
    hi_cnt = 0;
    pulse_cnt = 0;
    moved = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (sync_o[0][0]) hi_cnt++;
      if (rise_o[0][0] || fall_o[0][0]) pulse_cnt++;
      if (filt_o[0][0]) moved = 1'b1;
      async_in[0] = (k >= 1 && k <= 3);
    end
    check("glitch.sync_width", 32'(hi_cnt), 32'd3);
    check("glitch.pulses", 32'(pulse_cnt), 32'd0);
    check("glitch.filt_moved", 32'(moved), 32'd0);

    // Simultaneous rise on bit1 and fall on bit3
    @(negedge clk);
    async_in = 4'b1000;
    repeat (20) @(negedge clk);
    async_in = 4'b0010;
    wait_any0(20, edges, found);
    check("simul.found", 32'(found), 32'd1);
    check("simul.latency", 32'(edges), 32'd7);
    check("simul.rise", 32'(rise_o[0]), 32'b0010);
    check("simul.fall", 32'(fall_o[0]), 32'b1000);
    @(posedge clk);
    #1;
    check("simul.any_next", 32'(any_o[0]), 32'h0);

    // Mid-operation reset with a pending bit2 transition
    @(negedge clk);
    async_in = 4'b0110;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst.filt", 32'(filt_o[0]), 32'h0);
    check("midrst.sync", 32'(sync_o[0]), 32'h0);
    check("midrst.pulses", 32'({rise_o[0], fall_o[0]}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_any0(20, edges, found);
    check("midrst.found", 32'(found), 32'd1);
    check("midrst.latency", 32'(edges), 32'd7);
    check("midrst.rise", 32'(rise_o[0]), 32'b0110);

    // Randomised levels with random hold times (mix of glitches and accepts)
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 10);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        hold[c] = hold[c] - 1;
        if (hold[c] == 0) begin
          async_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 10);
        end
      end
`ifdef SYNC_FILTER_EVENT_CNT_EN
      evt_clr = ($urandom_range(0, 63) == 0);
`endif
    end

`ifdef SYNC_FILTER_EVENT_CNT_EN
    @(negedge clk);
    evt_clr = 1'b0;
    async_in = 4'h0;
    repeat (15) @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      async_in[0] = 1'b1;
      repeat (12) @(negedge clk);
      async_in[0] = 1'b0;
      repeat (12) @(negedge clk);
    end
    check("evt.saturate", 32'(evt_o[0][7:0]), 32'd255);
    async_in[0] = 1'b1;
    wait_any0(20, edges, found);
    check("evt.rise_found", 32'(found), 32'd1);
    evt_clr = 1'b1;
    @(posedge clk);
    #1;
    evt_clr = 1'b0;
    check("evt.clear_wins", 32'(evt_o[0][7:0]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
